// File: rtl/wb_sched_pkg.sv
// Shared FSM state type and width helpers for the Wishbone round-robin scheduler.
package wb_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_OWN   = 2'd1,
    S_ABORT = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  // BROKEN_CLOG2 selects a loop for tools whose $clog2 is unusable in constant context.
  function automatic int clog2(input int v);
`ifdef BROKEN_CLOG2
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
`else
    return $clog2(v);
`endif
  endfunction

  function automatic int sel_bits(input int n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_sched_rr_pick.sv
// Combinational rotate-priority picker: first requester at or after ptr, wrapping.
// Zero latency; valid is simply the OR of all requests.
module wb_sched_rr_pick
  import wb_sched_pkg::*;
#(
  parameter int num_masters = 2,
  parameter int sel_w       = sel_bits(num_masters)
) (
  input  logic [num_masters-1:0] req,
  input  logic [sel_w-1:0]       ptr,
  output logic [num_masters-1:0] onehot,
  output logic [sel_w-1:0]       index,
  output logic                   valid
);

  always_comb begin
    int   j;
    logic found;
    onehot = '0;
    index  = '0;
    found  = 1'b0;
    j      = 0;
    for (int k = 0; k < num_masters; k++) begin
      j = int'(ptr) + k;
      if (j >= num_masters) j = j - num_masters;
      if (!found && req[j]) begin
        found     = 1'b1;
        onehot[j] = 1'b1;
        index     = sel_w'(j);
      end
    end
  end

  assign valid = |req;

endmodule

// File: rtl/wb_rr_scheduler.sv
// Round-robin sharing of one Wishbone slave port; grant 1 cycle after cyc, held until the owner drops cyc.
// Define WB_SCHED_TIMEOUT_EN to add a stall watchdog that aborts the owner's cycle with err.
module wb_rr_scheduler
  import wb_sched_pkg::*;
#(
  parameter int dw          = 32,
  parameter int aw          = 32,
  parameter int num_masters = 2,
  parameter int timeout     = 255
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_i,
  input  logic [num_masters*aw-1:0] wbm_adr_i,
  input  logic [num_masters*dw-1:0] wbm_dat_i,
  input  logic [num_masters*4-1:0]  wbm_sel_i,
  input  logic [num_masters-1:0]    wbm_we_i,
  input  logic [num_masters-1:0]    wbm_cyc_i,
  input  logic [num_masters-1:0]    wbm_stb_i,
  input  logic [num_masters*3-1:0]  wbm_cti_i,
  input  logic [num_masters*2-1:0]  wbm_bte_i,
  output logic [num_masters*dw-1:0] wbm_dat_o,
  output logic [num_masters-1:0]    wbm_ack_o,
  output logic [num_masters-1:0]    wbm_err_o,
  output logic [num_masters-1:0]    wbm_rty_o,
  output logic [aw-1:0]             wbs_adr_o,
  output logic [dw-1:0]             wbs_dat_o,
  output logic [3:0]                wbs_sel_o,
  output logic                      wbs_we_o,
  output logic                      wbs_cyc_o,
  output logic                      wbs_stb_o,
  output logic [2:0]                wbs_cti_o,
  output logic [1:0]                wbs_bte_o,
  input  logic [dw-1:0]             wbs_dat_i,
  input  logic                      wbs_ack_i,
  input  logic                      wbs_err_i,
  input  logic                      wbs_rty_i,
  output logic [num_masters-1:0]    grant_o,
  output logic                      active_o
);

  localparam int SW = sel_bits(num_masters);

  state_t                 state_q, state_d;
  logic [SW-1:0]          owner_q, owner_d;
  logic [SW-1:0]          ptr_q, ptr_d, ptr_next;
  logic [num_masters-1:0] grant_q, grant_d;

  logic [num_masters-1:0] pick_onehot;
  logic [SW-1:0]          pick_idx;
  logic                   pick_vld;
  logic                   st_own, own_cyc, wd_fire;

  wb_sched_rr_pick #(.num_masters(num_masters), .sel_w(SW)) u_pick (
    .req    (wbm_cyc_i),
    .ptr    (ptr_q),
    .onehot (pick_onehot),
    .index  (pick_idx),
    .valid  (pick_vld)
  );

  assign st_own   = (state_q == S_OWN);
  assign own_cyc  = wbm_cyc_i[owner_q];
  assign ptr_next = (owner_q == SW'(num_masters - 1)) ? '0 : owner_q + SW'(1);

`ifdef WB_SCHED_TIMEOUT_EN
  localparam int              CW  = clog2(timeout + 1);
  localparam logic [CW-1:0]   LIM = CW'(timeout - 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          stall;

  assign stall   = wbs_stb_o & ~(wbs_ack_i | wbs_err_i | wbs_rty_i);
  assign wd_fire = stall && (cnt_q == LIM);

  // Any response, stb low or leaving OWN restarts the stall count.
  always_comb cnt_d = (st_own && state_d == S_OWN && stall) ? cnt_q + CW'(1) : '0;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end
`else
  logic unused_timeout;
  assign unused_timeout = (timeout > 1);
  assign wd_fire        = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          state_d = S_OWN;
          owner_d = pick_idx;
          grant_d = pick_onehot;
        end
      end
      S_OWN: begin
        if (!own_cyc) begin
          state_d = S_IDLE;
          ptr_d   = ptr_next;
          grant_d = '0;
        end else if (wd_fire) begin
          state_d = S_ABORT;
        end
      end
      S_ABORT, S_DRAIN: begin
        if (!own_cyc) begin
          state_d = S_IDLE;
          ptr_d   = ptr_next;
          grant_d = '0;
        end else begin
          state_d = S_DRAIN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= S_IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
    end
  end

  assign wbs_adr_o = wbm_adr_i[int'(owner_q)*aw +: aw];
  assign wbs_dat_o = wbm_dat_i[int'(owner_q)*dw +: dw];
  assign wbs_sel_o = wbm_sel_i[int'(owner_q)*4 +: 4];
  assign wbs_cti_o = wbm_cti_i[int'(owner_q)*3 +: 3];
  assign wbs_bte_o = wbm_bte_i[int'(owner_q)*2 +: 2];
  assign wbs_cyc_o = st_own & own_cyc;
  assign wbs_stb_o = st_own & own_cyc & wbm_stb_i[owner_q];
  assign wbs_we_o  = st_own & wbm_we_i[owner_q];

  assign wbm_dat_o = {num_masters{wbs_dat_i}};
  assign wbm_ack_o = {num_masters{st_own & wbs_ack_i}} & grant_q;
  assign wbm_rty_o = {num_masters{st_own & wbs_rty_i}} & grant_q;
  assign wbm_err_o = {num_masters{(st_own & wbs_err_i) | (state_q == S_ABORT)}} & grant_q;

  assign grant_o  = grant_q;
  assign active_o = st_own;

endmodule
